// File: rtl/xvga_pkg.sv
// Shared XVGA raster constants and coordinate widths for the timing generator
// and every pixel generator that consumes hcount/vcount.
package xvga_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Half-open window test at 12 bits so boundary sums never wrap.
    function automatic logic in_window(logic [11:0] pos, logic [11:0] lo, logic [11:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/xvga_timing_if.sv
// Raster coordinate/sync bundle from the timing generator to the video pipeline.
// Carries the delayed syncs only when SYNC_DELAY_EN is defined.
interface xvga_timing_if;

    logic [xvga_pkg::HCOUNT_W-1:0] hcount;
    logic [xvga_pkg::VCOUNT_W-1:0] vcount;
    logic                          hsync;
    logic                          vsync;
    logic                          blank;
    logic                          line_start;
    logic                          frame_start;
`ifdef SYNC_DELAY_EN
    logic                          hsync_d;
    logic                          vsync_d;
    logic                          blank_d;

    modport master (output hcount, vcount, hsync, vsync, blank, line_start, frame_start,
                           hsync_d, vsync_d, blank_d);
    modport slave  (input  hcount, vcount, hsync, vsync, blank, line_start, frame_start,
                           hsync_d, vsync_d, blank_d);
`else
    modport master (output hcount, vcount, hsync, vsync, blank, line_start, frame_start);
    modport slave  (input  hcount, vcount, hsync, vsync, blank, line_start, frame_start);
`endif

endinterface

// File: rtl/sync_delay_line.sv
// ce-qualified shift register with synchronous clear to a configurable idle value.
module sync_delay_line #(
    parameter int                 WIDTH   = 1,
    parameter int                 DEPTH   = 2,
    parameter logic [WIDTH-1:0]   CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d = stage_q;
        if (ce) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= CLR_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/xvga_timing.sv
// XVGA raster timing generator: free-running hcount/vcount with registered syncs and blank.
// Optional macro SYNC_DELAY_EN adds hsync_d/vsync_d/blank_d delayed by SYNC_DELAY ce stages.
module xvga_timing
    import xvga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int SYNC_DELAY = 2
) (
    input  logic          vclock,
    input  logic          reset,
    input  logic          ce,
    xvga_timing_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT12 = 12'(H_ACTIVE);
    localparam logic [11:0] HS_LO   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_HI   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT12 = 12'(V_ACTIVE);
    localparam logic [11:0] VS_LO   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_HI   = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_TOTAL - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_TOTAL - 1);

    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
        $error("xvga_timing: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("xvga_timing: porch and sync widths must be non-zero");
    end
    if (SYNC_DELAY < 1) begin : g_bad_delay
        $error("xvga_timing: SYNC_DELAY must be at least 1");
    end

    logic [HCOUNT_W-1:0] hcount_q, hcount_d, hcount_nx;
    logic [VCOUNT_W-1:0] vcount_q, vcount_d, vcount_nx;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                blank_q, blank_d;
    logic                line_start_q, line_start_d;
    logic                frame_start_q, frame_start_d;
    logic                h_wrap, v_wrap;

    // Decode uses the next count so syncs/blank line up with the coordinate they accompany.
    always_comb begin
        h_wrap    = (hcount_q == H_LAST);
        v_wrap    = (vcount_q == V_LAST);
        hcount_nx = h_wrap ? '0 : hcount_q + 1'b1;
        vcount_nx = h_wrap ? (v_wrap ? '0 : vcount_q + 1'b1) : vcount_q;

        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_d       = blank_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (ce) begin
            hcount_d      = hcount_nx;
            vcount_d      = vcount_nx;
            hsync_d       = in_window({1'b0, hcount_nx}, HS_LO, HS_HI) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = in_window({2'b0, vcount_nx}, VS_LO, VS_HI) ? VSYNC_POL : ~VSYNC_POL;
            blank_d       = ({1'b0, hcount_nx} >= H_ACT12) || ({2'b0, vcount_nx} >= V_ACT12);
            line_start_d  = (hcount_nx == '0);
            frame_start_d = (hcount_nx == '0) && (vcount_nx == '0);
        end
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.hcount      = hcount_q;
    assign vid.vcount      = vcount_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.blank       = blank_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

`ifdef SYNC_DELAY_EN
    localparam logic [2:0] SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    logic [2:0] dly_out;

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DELAY),
        .CLR_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk  (vclock),
        .rst  (reset),
        .ce   (ce),
        .din  ({hsync_q, vsync_q, blank_q}),
        .dout (dly_out)
    );

    assign vid.hsync_d = dly_out[2];
    assign vid.vsync_d = dly_out[1];
    assign vid.blank_d = dly_out[0];
`endif

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing: default-timing checkpoints from a vector table, plus a small
// 14x7 raster checked cycle by cycle (and the delayed syncs when SYNC_DELAY_EN is set).
module tb_xvga_timing;
    import xvga_pkg::*;

    localparam int SD = 2;

    logic vclock = 1'b0;
    always #5 vclock = ~vclock;

    logic rst_def, ce_def, rst_sm, ce_sm;

    xvga_timing_if if_def();
    xvga_timing_if if_sm();

    xvga_timing u_def (
        .vclock (vclock),
        .reset  (rst_def),
        .ce     (ce_def),
        .vid    (if_def)
    );

    xvga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_DELAY(SD)
    ) u_sm (
        .vclock (vclock),
        .reset  (rst_sm),
        .ce     (ce_sm),
        .vid    (if_sm)
    );

    typedef struct {
        logic [31:0] h;
        logic [31:0] v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int   cycles;
        bit   rst;
        bit   ce;
        obs_t exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    obs_t sb[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(string tag, obs_t a, obs_t e);
        check({tag, ".hcount"},      a.h, e.h);
        check({tag, ".vcount"},      a.v, e.v);
        check({tag, ".hsync"},       32'(a.hs), 32'(e.hs));
        check({tag, ".vsync"},       32'(a.vs), 32'(e.vs));
        check({tag, ".blank"},       32'(a.bl), 32'(e.bl));
        check({tag, ".line_start"},  32'(a.ls), 32'(e.ls));
        check({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
    endtask

    function automatic obs_t mk_obs(int h, int v, bit hs, bit vs, bit bl, bit ls, bit fs);
        obs_t o;
        o.h = 32'(h); o.v = 32'(v);
        o.hs = hs; o.vs = vs; o.bl = bl; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic vec_t mk(int n, bit r, bit c, int h, int v, bit hs, bit vs, bit bl, bit ls, bit fs);
        vec_t t;
        t.cycles = n; t.rst = r; t.ce = c;
        t.exp = mk_obs(h, v, hs, vs, bl, ls, fs);
        return t;
    endfunction

    // Reference for the 14x7 raster: hsync low at h 10..11, vsync low at v 5, blank h>=8 or v>=4.
    function automatic obs_t model_sm(int h, int v, bit ls, bit fs);
        return mk_obs(h, v, !(h >= 10 && h < 12), !(v == 5), (h >= 8) || (v >= 4), ls, fs);
    endfunction

    function automatic obs_t samp_def();
        obs_t o;
        o.h  = 32'(if_def.hcount);
        o.v  = 32'(if_def.vcount);
        o.hs = if_def.hsync;
        o.vs = if_def.vsync;
        o.bl = if_def.blank;
        o.ls = if_def.line_start;
        o.fs = if_def.frame_start;
        return o;
    endfunction

    function automatic obs_t samp_sm();
        obs_t o;
        o.h  = 32'(if_sm.hcount);
        o.v  = 32'(if_sm.vcount);
        o.hs = if_sm.hsync;
        o.vs = if_sm.vsync;
        o.bl = if_sm.blank;
        o.ls = if_sm.line_start;
        o.fs = if_sm.frame_start;
        return o;
    endfunction

    initial begin
        obs_t       a, e, cur;
        int         mh, mv, cyc, last_fs, n_fs;
        bit         c, ls, fs;
        logic       prev_vs;
        logic [2:0] dq[$];

        rst_def = 1'b1; ce_def = 1'b1;
        rst_sm  = 1'b1; ce_sm  = 1'b0;

        //          cyc   rst ce  h     v  hs vs bl ls fs
        vecs.push_back(mk(1,    1, 1, 0,    0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1,    0, 1, 1,    0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1022, 0, 1, 1023, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1,    0, 1, 1024, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(23,   0, 1, 1047, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1,    0, 1, 1048, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(135,  0, 1, 1183, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1,    0, 1, 1184, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(159,  0, 1, 1343, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1,    0, 1, 0,    1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(10,   0, 1, 10,   1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 10,   1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 10,   1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1,    0, 1, 11,   1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1037, 0, 1, 1048, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(2,    0, 0, 1048, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(295,  0, 1, 1343, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1,    0, 1, 0,    2, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1,    0, 0, 0,    2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 0,    2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1,    0, 1, 1,    2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1342, 0, 1, 1343, 2, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1,    0, 1, 0,    3, 1, 1, 0, 1, 0));
        vecs.push_back(mk(500,  0, 1, 500,  3, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 0,    0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1,    0, 1, 1,    0, 1, 1, 0, 0, 0));

        // Default timing: checkpoints from the vector table.
        foreach (vecs[i]) begin
            rst_def = vecs[i].rst;
            ce_def  = vecs[i].ce;
            sb.push_back(vecs[i].exp);
            repeat (vecs[i].cycles) @(posedge vclock);
            #1;
            a = samp_def();
            e = sb.pop_front();
            cmp_obs($sformatf("def[%0d]", i), a, e);
        end
        rst_def = 1'b0;
        ce_def  = 1'b0;

        // Small raster: reset, then two full frames at ce=1 against the model.
        rst_sm = 1'b1; ce_sm = 1'b1;
        sb.push_back(model_sm(0, 0, 1, 1));
        @(posedge vclock); #1;
        a = samp_sm(); e = sb.pop_front();
        cmp_obs("sm_reset", a, e);
        rst_sm = 1'b0;
        mh = 0; mv = 0; last_fs = 0; n_fs = 0; prev_vs = a.vs;
        for (cyc = 1; cyc <= 196; cyc++) begin
            mh = (mh == 13) ? 0 : mh + 1;
            if (mh == 0) mv = (mv == 6) ? 0 : mv + 1;
            sb.push_back(model_sm(mh, mv, mh == 0, mh == 0 && mv == 0));
            @(posedge vclock); #1;
            a = samp_sm(); e = sb.pop_front();
            cmp_obs($sformatf("sm[%0d]", cyc), a, e);
            if (a.vs !== prev_vs) check("vsync_edge_at_h0", a.h, 0);
            prev_vs = a.vs;
            if (a.fs === 1'b1) begin
                n_fs++;
                check("frame_period", 32'(cyc - last_fs), 32'd98);
                last_fs = cyc;
            end
        end
        check("frame_start_count", 32'(n_fs), 32'd2);

        // Small raster with ce gaps; reset is applied with ce low to show it wins.
        rst_sm = 1'b1; ce_sm = 1'b0;
        sb.push_back(model_sm(0, 0, 1, 1));
        @(posedge vclock); #1;
        a = samp_sm(); e = sb.pop_front();
        cmp_obs("sm_reset_ce0", a, e);
        rst_sm = 1'b0;
        mh = 0; mv = 0;
        dq.delete();
        for (int k = 0; k < SD; k++) dq.push_back(3'b110);
`ifdef SYNC_DELAY_EN
        check("hsync_d_reset", 32'(if_sm.hsync_d), 32'd1);
        check("blank_d_reset", 32'(if_sm.blank_d), 32'd0);
`endif
        for (int i = 0; i < 90; i++) begin
            c = !((i % 7 == 2) || (i % 7 == 3) || (i % 11 == 5));
            ce_sm = c;
            cur = model_sm(mh, mv, 0, 0);
            ls = 1'b0; fs = 1'b0;
            if (c) begin
                dq.push_back({cur.hs, cur.vs, cur.bl});
                void'(dq.pop_front());
                mh = (mh == 13) ? 0 : mh + 1;
                if (mh == 0) mv = (mv == 6) ? 0 : mv + 1;
                ls = (mh == 0);
                fs = (mh == 0) && (mv == 0);
            end
            sb.push_back(model_sm(mh, mv, ls, fs));
            @(posedge vclock); #1;
            a = samp_sm(); e = sb.pop_front();
            cmp_obs($sformatf("gap[%0d]", i), a, e);
`ifdef SYNC_DELAY_EN
            check($sformatf("gap[%0d].hsync_d", i), 32'(if_sm.hsync_d), 32'(dq[0][2]));
            check($sformatf("gap[%0d].vsync_d", i), 32'(if_sm.vsync_d), 32'(dq[0][1]));
            check($sformatf("gap[%0d].blank_d", i), 32'(if_sm.blank_d), 32'(dq[0][0]));
`endif
        end
        ce_sm = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
